// File: rtl/wb_hid_queue_pkg.sv
// Shared constants for the HID report queue: register map, control/status bit
// positions and the layout of one queued entry.
package wb_hid_queue_pkg;

  localparam int ENTRY_W    = 69;
  localparam int REPORT_LSB = 0;
  localparam int TYP_LSB    = 64;
  localparam int CONERR_BIT = 66;
  localparam int CH_LSB     = 67;

  localparam logic [3:0] ADR_CTRL      = 4'd0;
  localparam logic [3:0] ADR_STATUS    = 4'd1;
  localparam logic [3:0] ADR_LEVEL     = 4'd2;
  localparam logic [3:0] ADR_HEAD_INFO = 4'd3;
  localparam logic [3:0] ADR_HEAD_LO   = 4'd4;
  localparam logic [3:0] ADR_HEAD_HI   = 4'd5;
  localparam logic [3:0] ADR_POP       = 4'd6;
  localparam logic [3:0] ADR_DROP_CNT  = 4'd7;

  localparam int CTRL_IEN        = 0;
  localparam int CTRL_MODE       = 1;
  localparam int CTRL_AUTOPOP    = 2;
  localparam int CTRL_THRESH_LSB = 8;
  localparam int CTRL_EN_LSB     = 16;

  localparam int STATUS_COND = 0;
  localparam int STATUS_OVF  = 1;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [1:0]  ch,
    input logic        conerr,
    input logic [1:0]  typ,
    input logic [63:0] report
  );
    return {ch, conerr, typ, report};
  endfunction

endpackage

// File: rtl/hid_report_fifo.sv
// Synchronous FIFO with a combinational head; push is refused while full and
// pop is refused while empty, both judged on the registered count.
module hid_report_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 16
) (
  input  logic                     wb_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage has no reset; an empty FIFO never exposes it.
  always_ff @(posedge wb_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge wb_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_hid_report_queue.sv
// Wishbone slave collecting HID reports from up to four channels into one FIFO,
// with per-channel pending registers, round-robin arbitration and an IRQ.
module wb_hid_report_queue
  import wb_hid_queue_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16
) (
  input  logic                  wb_clk,
  input  logic                  sys_rst_n,
  input  logic [NUM_CH-1:0]     ch_report_stb,
  input  logic [2*NUM_CH-1:0]   ch_typ,
  input  logic [NUM_CH-1:0]     ch_conerr,
  input  logic [64*NUM_CH-1:0]  ch_report,
  output logic                  irq,
  input  logic [3:0]            wbs_adr,
  input  logic [31:0]           wbs_dat_w,
  output logic [31:0]           wbs_dat_r,
  input  logic [3:0]            wbs_sel,
  input  logic                  wbs_cyc,
  input  logic                  wbs_stb,
  input  logic                  wbs_we,
  output logic                  wbs_ack,
  output logic                  wbs_stall,
  output logic                  wbs_err
);
  localparam int MAX_CH = 4;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam logic [3:0] EN_MASK = 4'((1 << NUM_CH) - 1);

  logic               ien, mode, autopop, ovf;
  logic [7:0]         thresh;
  logic [3:0]         en;
  logic [15:0]        drop_cnt;

  logic [MAX_CH-1:0]  pend;
  logic [ENTRY_W-1:0] pend_data [MAX_CH];
  logic [1:0]         rr;

  logic [MAX_CH-1:0]  stb_ext, conerr_ext, cap, drop;
  logic [1:0]         typ_ext    [MAX_CH];
  logic [63:0]        report_ext [MAX_CH];

  logic               win_valid, push;
  logic [1:0]         win_idx, rr_next;
  logic [2:0]         cand, rr_inc, ndrop;
  logic [16:0]        drop_sum;

  logic               wb_wr, wb_rd, pop_req, cond;
  logic [ENTRY_W-1:0] head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;
  logic [8:0]         level;
  logic               unused_sig;

  // Channels above NUM_CH are padded to zero so the arbiter is always 4 wide.
  always_comb begin
    stb_ext    = '0;
    conerr_ext = '0;
    for (int c = 0; c < MAX_CH; c++) begin
      typ_ext[c]    = '0;
      report_ext[c] = '0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      stb_ext[c]    = ch_report_stb[c];
      conerr_ext[c] = ch_conerr[c];
      typ_ext[c]    = ch_typ[2*c +: 2];
      report_ext[c] = ch_report[64*c +: 64];
    end
  end

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr} + 3'(i);
      if (cand >= 3'(NUM_CH)) cand = cand - 3'(NUM_CH);
      if (!win_valid && pend[cand[1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  assign push    = win_valid & ~fifo_full;
  assign rr_inc  = {1'b0, win_idx} + 3'd1;
  assign rr_next = (rr_inc >= 3'(NUM_CH)) ? 2'd0 : rr_inc[1:0];

  // A strobe on the channel being pushed this cycle refills its slot, not a drop.
  always_comb begin
    cap   = '0;
    drop  = '0;
    ndrop = '0;
    for (int c = 0; c < MAX_CH; c++) begin
      cap[c]  = stb_ext[c] & en[c] & (typ_ext[c] != 2'b00);
      drop[c] = cap[c] & pend[c] & ~(push & (win_idx == 2'(c)));
      ndrop   = ndrop + 3'(drop[c]);
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(ndrop);

  always_ff @(posedge wb_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend <= '0;
      rr   <= '0;
      for (int c = 0; c < MAX_CH; c++) pend_data[c] <= '0;
    end else begin
      for (int c = 0; c < MAX_CH; c++) begin
        if (cap[c]) begin
          pend[c]      <= 1'b1;
          pend_data[c] <= pack_entry(2'(c), conerr_ext[c], typ_ext[c], report_ext[c]);
        end else if (push && (win_idx == 2'(c))) begin
          pend[c] <= 1'b0;
        end
      end
      if (push) rr <= rr_next;
    end
  end

  hid_report_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .wb_clk    (wb_clk),
    .sys_rst_n (sys_rst_n),
    .push      (push),
    .push_data (pend_data[win_idx]),
    .pop       (pop_req),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wb_wr   = wbs_cyc & wbs_stb & wbs_we;
  assign wb_rd   = wbs_cyc & wbs_stb & ~wbs_we;
  assign pop_req = (wb_wr && wbs_adr == ADR_POP) ||
                   (wb_rd && wbs_adr == ADR_HEAD_HI && autopop);

  always_ff @(posedge wb_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ien      <= 1'b0;
      mode     <= 1'b0;
      autopop  <= 1'b0;
      thresh   <= '0;
      en       <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
      wbs_ack  <= 1'b0;
    end else begin
      wbs_ack <= wbs_stb & wbs_cyc;
      if (wb_wr && wbs_adr == ADR_CTRL) begin
        ien     <= wbs_dat_w[CTRL_IEN];
        mode    <= wbs_dat_w[CTRL_MODE];
        autopop <= wbs_dat_w[CTRL_AUTOPOP];
        thresh  <= wbs_dat_w[CTRL_THRESH_LSB +: 8];
        en      <= wbs_dat_w[CTRL_EN_LSB +: 4] & EN_MASK;
      end
      // Software clears take priority over a drop in the same cycle.
      if (wb_wr && wbs_adr == ADR_DROP_CNT) drop_cnt <= '0;
      else if (|drop) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (wb_wr && wbs_adr == ADR_STATUS && wbs_dat_w[STATUS_OVF]) ovf <= 1'b0;
      else if (|drop) ovf <= 1'b1;
    end
  end

  assign level = 9'(fifo_count);
  assign cond  = mode ? ((level >= {1'b0, thresh}) && (thresh != 8'd0))
                      : (level != 9'd0);
  assign irq   = ien & (cond | ovf);

  always_comb begin
    wbs_dat_r = '0;
    case (wbs_adr)
      ADR_CTRL:      wbs_dat_r = {12'h0, en, thresh, 5'h0, autopop, mode, ien};
      ADR_STATUS:    wbs_dat_r = {30'h0, ovf, cond};
      ADR_LEVEL:     wbs_dat_r = {23'h0, level};
      ADR_HEAD_INFO: if (!fifo_empty)
                       wbs_dat_r = {1'b1, 25'h0, head[CH_LSB +: 2], 1'b0,
                                    head[CONERR_BIT], head[TYP_LSB +: 2]};
      ADR_HEAD_LO:   if (!fifo_empty) wbs_dat_r = head[REPORT_LSB +: 32];
      ADR_HEAD_HI:   if (!fifo_empty) wbs_dat_r = head[REPORT_LSB + 32 +: 32];
      ADR_DROP_CNT:  wbs_dat_r = {16'h0, drop_cnt};
      default:       wbs_dat_r = '0;
    endcase
  end

  assign wbs_stall  = 1'b0;
  assign wbs_err    = 1'b0;
  assign unused_sig = ^{wbs_sel, wbs_dat_w[31:20], wbs_dat_w[7:3]};

endmodule
